// File: rtl/bcd_to_clock_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_to_clock_if                                                      |
// | Digit-entry handshake between a time-set source and bcd_to_clock.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface bcd_to_clock_if;
  logic [3:0] i_digit;
  logic       i_digit_valid;
  logic       o_digit_ready;
  logic       i_abort;

  modport master (
    output i_digit,
    output i_digit_valid,
    output i_abort,
    input  o_digit_ready
  );

  modport slave (
    input  i_digit,
    input  i_digit_valid,
    input  i_abort,
    output o_digit_ready
  );
endinterface
`default_nettype wire

// File: rtl/bcd_to_clock.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_to_clock                                                         |
// | Serial HH MM SS BCD digit loader producing a binary time-load strobe.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bcd_to_clock (
  input  wire logic       i_clk,
  input  wire logic       i_reset,
  bcd_to_clock_if.slave   digit_bus,
  output logic [2:0]      o_digit_idx,
  output logic [4:0]      o_hours,
  output logic [5:0]      o_minutes,
  output logic [5:0]      o_seconds,
  output logic            o_load,
  output logic            o_error
);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    COMMIT  = 1'b1
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_idx, w_idx_nxt;
  logic [3:0] r_tens, w_tens_nxt;
  logic [4:0] r_stage_hours, w_stage_hours_nxt;
  logic [5:0] r_stage_minutes, w_stage_minutes_nxt;
  logic [4:0] r_hours, w_hours_nxt;
  logic [5:0] r_minutes, w_minutes_nxt;
  logic [5:0] r_seconds, w_seconds_nxt;
  logic       r_error, w_error_nxt;
  logic       w_ready;
  logic       w_digit_ok;
  logic [6:0] w_pair;

  assign w_ready = (r_state == COLLECT) && !digit_bus.i_abort;
  assign digit_bus.o_digit_ready = w_ready;

  // tens*10 + units built from shifts; range checks keep it within 59
  assign w_pair = {r_tens, 3'b000} + {2'b00, r_tens, 1'b0} + {3'b000, digit_bus.i_digit};

  always_comb begin
    w_digit_ok = 1'b0;
    case (r_idx)
      3'd0:    w_digit_ok = (digit_bus.i_digit <= 4'd2);
      3'd1:    w_digit_ok = (digit_bus.i_digit <= 4'd9) &&
                            !((r_tens == 4'd2) && (digit_bus.i_digit > 4'd3));
      3'd2:    w_digit_ok = (digit_bus.i_digit <= 4'd5);
      3'd3:    w_digit_ok = (digit_bus.i_digit <= 4'd9);
      3'd4:    w_digit_ok = (digit_bus.i_digit <= 4'd5);
      3'd5:    w_digit_ok = (digit_bus.i_digit <= 4'd9);
      default: w_digit_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_idx_nxt           = r_idx;
    w_tens_nxt          = r_tens;
    w_stage_hours_nxt   = r_stage_hours;
    w_stage_minutes_nxt = r_stage_minutes;
    w_hours_nxt         = r_hours;
    w_minutes_nxt       = r_minutes;
    w_seconds_nxt       = r_seconds;
    w_error_nxt         = 1'b0;
    case (r_state)
      COMMIT: begin
        w_state_nxt = COLLECT;
        w_idx_nxt   = 3'd0;
      end
      default: begin
        if (digit_bus.i_abort) begin
          w_idx_nxt           = 3'd0;
          w_tens_nxt          = 4'd0;
          w_stage_hours_nxt   = 5'd0;
          w_stage_minutes_nxt = 6'd0;
        end else if (digit_bus.i_digit_valid) begin
          if (w_digit_ok) begin
            w_idx_nxt = r_idx + 3'd1;
            case (r_idx)
              3'd1:    w_stage_hours_nxt   = w_pair[4:0];
              3'd3:    w_stage_minutes_nxt = w_pair[5:0];
              3'd5: begin
                w_hours_nxt   = r_stage_hours;
                w_minutes_nxt = r_stage_minutes;
                w_seconds_nxt = w_pair[5:0];
                w_idx_nxt     = 3'd0;
                w_state_nxt   = COMMIT;
              end
              default: w_tens_nxt = digit_bus.i_digit;
            endcase
          end else begin
            w_idx_nxt           = 3'd0;
            w_tens_nxt          = 4'd0;
            w_stage_hours_nxt   = 5'd0;
            w_stage_minutes_nxt = 6'd0;
            w_error_nxt         = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= COLLECT;
      r_idx           <= 3'd0;
      r_tens          <= 4'd0;
      r_stage_hours   <= 5'd0;
      r_stage_minutes <= 6'd0;
      r_hours         <= 5'd0;
      r_minutes       <= 6'd0;
      r_seconds       <= 6'd0;
      r_error         <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_idx           <= w_idx_nxt;
      r_tens          <= w_tens_nxt;
      r_stage_hours   <= w_stage_hours_nxt;
      r_stage_minutes <= w_stage_minutes_nxt;
      r_hours         <= w_hours_nxt;
      r_minutes       <= w_minutes_nxt;
      r_seconds       <= w_seconds_nxt;
      r_error         <= w_error_nxt;
    end
  end

  assign o_digit_idx = r_idx;
  assign o_hours     = r_hours;
  assign o_minutes   = r_minutes;
  assign o_seconds   = r_seconds;
  assign o_load      = (r_state == COMMIT);
  assign o_error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_clock.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bcd_to_clock                                                      |
// | Directed self-checking bench for the BCD time loader.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_bcd_to_clock;
  logic       clk;
  logic       rst;
  logic [2:0] digit_idx;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       load;
  logic       error;
  int         n_checks;
  int         n_pass;

  bcd_to_clock_if bus ();

  bcd_to_clock dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .digit_bus   (bus.slave),
    .o_digit_idx (digit_idx),
    .o_hours     (hours),
    .o_minutes   (minutes),
    .o_seconds   (seconds),
    .o_load      (load),
    .o_error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send(input logic [3:0] d);
    int waits = 0;
    while (!bus.o_digit_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 20) check("ready_timeout", int'(bus.o_digit_ready), 1);
    bus.i_digit       = d;
    bus.i_digit_valid = 1'b1;
    @(negedge clk);
    bus.i_digit_valid = 1'b0;
  endtask

  task automatic send6(input logic [3:0] d0, d1, d2, d3, d4, d5);
    send(d0); send(d1); send(d2); send(d3); send(d4); send(d5);
  endtask

  task automatic check_load(input string tag, input int h, input int m, input int s);
    check({tag, "_load"}, int'(load), 1);
    check({tag, "_ready_low"}, int'(bus.o_digit_ready), 0);
    check({tag, "_no_error"}, int'(error), 0);
    check({tag, "_hours"}, int'(hours), h);
    check({tag, "_minutes"}, int'(minutes), m);
    check({tag, "_seconds"}, int'(seconds), s);
    @(negedge clk);
    check({tag, "_load_drop"}, int'(load), 0);
  endtask

  task automatic check_error(input string tag, input int h, input int m, input int s);
    check({tag, "_error"}, int'(error), 1);
    check({tag, "_no_load"}, int'(load), 0);
    check({tag, "_idx"}, int'(digit_idx), 0);
    check({tag, "_ready"}, int'(bus.o_digit_ready), 1);
    check({tag, "_hours"}, int'(hours), h);
    check({tag, "_minutes"}, int'(minutes), m);
    check({tag, "_seconds"}, int'(seconds), s);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_load"}, int'(load), 0);
    check({tag, "_error"}, int'(error), 0);
    check({tag, "_idx"}, int'(digit_idx), 0);
    check({tag, "_ready"}, int'(bus.o_digit_ready), 1);
    check({tag, "_time"}, int'({hours, minutes, seconds}), 0);
  endtask

  initial begin
    logic [3:0] seq [6];
    n_checks = 0;
    n_pass   = 0;
    rst               = 1'b1;
    bus.i_digit       = 4'd0;
    bus.i_digit_valid = 1'b0;
    bus.i_abort       = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("reset");

    send6(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    check_load("t123456", 12, 34, 56);

    seq = '{4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9};
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check($sformatf("gap_idx%0d", i), int'(digit_idx), i);
      send(seq[i]);
    end
    check_load("t235959", 23, 59, 59);
    send6(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    check_load("t000000", 0, 0, 0);

    send6(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    check_load("reload", 12, 34, 56);
    send(4'd2); send(4'd4);
    check_error("err_hour24", 12, 34, 56);
    send6(4'd0, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0);
    check_load("t090000", 9, 0, 0);
    send(4'd1); send(4'd2); send(4'd3); send(4'hA);
    check_error("err_hexA", 9, 0, 0);
    send(4'd1); send(4'd2); send(4'd6);
    check_error("err_min60", 9, 0, 0);

    send(4'd1); send(4'd5); send(4'd3);
    check("abort_pre_idx", int'(digit_idx), 3);
    bus.i_abort       = 1'b1;
    bus.i_digit       = 4'd4;
    bus.i_digit_valid = 1'b1;
    #1 check("abort_ready_low", int'(bus.o_digit_ready), 0);
    @(negedge clk);
    bus.i_abort       = 1'b0;
    bus.i_digit_valid = 1'b0;
    check("abort_idx", int'(digit_idx), 0);
    check("abort_no_error", int'(error), 0);
    check("abort_hours_kept", int'(hours), 9);
    send6(4'd0, 4'd1, 4'd0, 4'd2, 4'd0, 4'd3);
    check_load("t010203", 1, 2, 3);

    send(4'd1); send(4'd1); send(4'd1); send(4'd1); send(4'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("rst_mid");
    @(negedge clk);
    check("rst_mid_quiet", int'(load), 0);

    send6(4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3);
    check("commit_before_rst", int'(load), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("rst_commit");

    send6(4'd1, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9);
    check_load("t195959", 19, 59, 59);
    send6(4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    check_load("t200000", 20, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
